wb_dest_sel_pipe: RTL and testbench

- Parametrised successor to the single-bit RegDest write-register mux.
- Selects the write-back destination register index from a 2-bit mode: rt, rd, or a link-register constant for jump-and-link.
- Registers the result behind a valid/ready handshake with a one-entry skid buffer.
- Keeps a pending-write scoreboard that the hazard logic queries. Sits between decode and the register-file write path.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_dest_sel_pipe_if.sv | 40 ++++
 rtl/wb_scoreboard.sv | 45 ++++
 rtl/wb_dest_sel_pipe.sv | 106 ++++++++++
 tb/tb_wb_dest_sel_pipe.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back destination select stage: select encoding
// and the {wreg, we} entry held in both the output and skid registers.
package wb_pkg;

  // Widest register index the shared entry type can carry.
  localparam int WB_REG_AW = 5;

  typedef enum logic [1:0] {
    DEST_RT   = 2'd0,
    DEST_RD   = 2'd1,
    DEST_LINK = 2'd2,
    DEST_ILL  = 2'd3
  } dest_sel_e;

  typedef struct packed {
    logic [WB_REG_AW-1:0] wreg;
    logic                 we;
  } wb_dest_t;

endpackage

// File: rtl/wb_dest_sel_pipe_if.sv
// Decode-side handshake, downstream handshake, retire and hazard-query signals
// of the write-back destination stage.
interface wb_dest_sel_pipe_if #(
  parameter int REG_AW = 5
);

  logic                   in_valid;
  logic                   in_ready;
  logic [REG_AW-1:0]      inst_rt;
  logic [REG_AW-1:0]      inst_rd;
  logic [1:0]             reg_dest_sel;
  logic                   reg_write;
  logic                   out_valid;
  logic                   out_ready;
  logic [REG_AW-1:0]      out_wreg;
  logic                   out_we;
  logic                   retire_valid;
  logic [REG_AW-1:0]      retire_reg;
  logic [REG_AW-1:0]      query_a;
  logic [REG_AW-1:0]      query_b;
  logic                   busy_a;
  logic                   busy_b;
  logic [2**REG_AW-1:0]   pending_mask;
  logic                   err_illegal;

  modport master (
    output in_valid, inst_rt, inst_rd, reg_dest_sel, reg_write,
    output out_ready, retire_valid, retire_reg, query_a, query_b,
    input  in_ready, out_valid, out_wreg, out_we,
    input  busy_a, busy_b, pending_mask, err_illegal
  );

  modport slave (
    input  in_valid, inst_rt, inst_rd, reg_dest_sel, reg_write,
    input  out_ready, retire_valid, retire_reg, query_a, query_b,
    output in_ready, out_valid, out_wreg, out_we,
    output busy_a, busy_b, pending_mask, err_illegal
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a write is issued,
// cleared when it retires; register 0 never shows as pending.
module wb_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_valid_i,
  input  logic [REG_AW-1:0]    set_reg_i,
  input  logic                 clr_valid_i,
  input  logic [REG_AW-1:0]    clr_reg_i,
  input  logic [REG_AW-1:0]    query_a_i,
  input  logic [REG_AW-1:0]    query_b_i,
  output logic                 busy_a_o,
  output logic                 busy_b_o,
  output logic [2**REG_AW-1:0] pending_mask_o
);

  logic [2**REG_AW-1:0] pending_q, pending_d;

  // Clear is applied before set so a newer write to the retiring index stays pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_valid_i) begin
      pending_d[clr_reg_i] = 1'b0;
    end
    if (set_valid_i) begin
      pending_d[set_reg_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_mask_o = pending_q;
  assign busy_a_o       = pending_q[query_a_i];
  assign busy_b_o       = pending_q[query_b_i];

endmodule

// File: rtl/wb_dest_sel_pipe.sv
// Write-back destination select: picks rt/rd/link, registers it behind a
// valid/ready handshake with a one-entry skid buffer, and tracks pending writes.
module wb_dest_sel_pipe
  import wb_pkg::*;
#(
  parameter int REG_AW   = WB_REG_AW,
  parameter int LINK_REG = 31
) (
  input logic               clk,
  input logic               rst,
  wb_dest_sel_pipe_if.slave bus
);

  wb_dest_t          out_q, out_d, skid_q, skid_d, new_entry;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              err_q, err_d;
  logic [REG_AW-1:0] sel_idx;
  logic              sel_ill;
  logic              we_eff;
  logic              accept;
  logic              drain;
  logic              sb_set;

  always_comb begin
    sel_idx = bus.inst_rt;
    sel_ill = 1'b0;
    case (dest_sel_e'(bus.reg_dest_sel))
      DEST_RT:   sel_idx = bus.inst_rt;
      DEST_RD:   sel_idx = bus.inst_rd;
      DEST_LINK: sel_idx = REG_AW'(LINK_REG);
      DEST_ILL:  sel_ill = 1'b1;
      default:   sel_ill = 1'b1;
    endcase
    we_eff         = bus.reg_write && !sel_ill && (sel_idx != '0);
    new_entry.wreg = WB_REG_AW'(sel_idx);
    new_entry.we   = we_eff;
  end

  // in_ready depends only on registered skid state, never on out_ready.
  assign bus.in_ready = !skid_valid_q && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = out_valid_q && bus.out_ready;
  assign sb_set       = accept && we_eff;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    err_d        = err_q || (accept && sel_ill);
    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_d       = new_entry;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      err_q        <= err_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_wreg    = out_q.wreg[REG_AW-1:0];
  assign bus.out_we      = out_q.we;
  assign bus.err_illegal = err_q;

  wb_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .set_valid_i    (sb_set),
    .set_reg_i      (sel_idx),
    .clr_valid_i    (bus.retire_valid),
    .clr_reg_i      (bus.retire_reg),
    .query_a_i      (bus.query_a),
    .query_b_i      (bus.query_b),
    .busy_a_o       (bus.busy_a),
    .busy_b_o       (bus.busy_b),
    .pending_mask_o (bus.pending_mask)
  );

endmodule

// File: tb/tb_wb_dest_sel_pipe.sv
// Self-checking bench for wb_dest_sel_pipe: an expected-destination queue plus
// a pending-mask model, checked every cycle and at directed points.
module tb_wb_dest_sel_pipe;

  localparam int REG_AW   = 5;
  localparam int LINK_REG = 31;

  typedef struct packed {
    logic [REG_AW-1:0] wreg;
    logic              we;
  } expEntry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_dest_sel_pipe_if #(.REG_AW(REG_AW)) bus ();

  wb_dest_sel_pipe #(
    .REG_AW   (REG_AW),
    .LINK_REG (LINK_REG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  expEntry_t            expQueue[$];
  expEntry_t            monEntry;
  expEntry_t            newEntry;
  logic                 monAccept;
  logic [2**REG_AW-1:0] modelMask = '0;
  logic [2**REG_AW-1:0] nextMask;
  logic                 modelErr = 1'b0;
  bit                   randomReady = 1'b0;
  int                   checkCount = 0;
  int                   errorCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic expEntry_t expectedDest(input logic [REG_AW-1:0] rt,
                                             input logic [REG_AW-1:0] rd,
                                             input logic [1:0] sel,
                                             input logic rw);
    expEntry_t e;
    case (sel)
      2'd1:    e.wreg = rd;
      2'd2:    e.wreg = REG_AW'(LINK_REG);
      default: e.wreg = rt;
    endcase
    e.we = rw && (sel != 2'd3) && (e.wreg != '0);
    return e;
  endfunction

  // Drives one instruction and waits (bounded) for the cycle it is accepted.
  task automatic applyStimulus(input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                               input logic [1:0] sel, input logic rw);
    bit   done = 1'b0;
    logic readySeen;
    bus.inst_rt      = rt;
    bus.inst_rd      = rd;
    bus.reg_dest_sel = sel;
    bus.reg_write    = rw;
    bus.in_valid     = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      readySeen = bus.in_ready;
      @(posedge clk);
      #1;
      if (readySeen) done = 1'b1;
    end
    checkOutput("acceptTimeout", 32'(done), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Per-cycle monitor: compare registered state, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      expQueue.delete();
      modelMask = '0;
      modelErr  = 1'b0;
    end else begin
      checkOutput("pendingMask", bus.pending_mask, modelMask);
      checkOutput("busyA", 32'(bus.busy_a), 32'(modelMask[bus.query_a]));
      checkOutput("busyB", 32'(bus.busy_b), 32'(modelMask[bus.query_b]));
      checkOutput("errIllegal", 32'(bus.err_illegal), 32'(modelErr));
      if (bus.out_valid && bus.out_ready) begin
        if (expQueue.size() == 0) begin
          checkOutput("outUnexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          monEntry = expQueue.pop_front();
          checkOutput("outWreg", 32'(bus.out_wreg), 32'(monEntry.wreg));
          checkOutput("outWe", 32'(bus.out_we), 32'(monEntry.we));
        end
      end
      monAccept = bus.in_valid && bus.in_ready;
      nextMask  = modelMask;
      if (bus.retire_valid && bus.retire_reg != '0) nextMask[bus.retire_reg] = 1'b0;
      if (monAccept) begin
        newEntry = expectedDest(bus.inst_rt, bus.inst_rd, bus.reg_dest_sel, bus.reg_write);
        expQueue.push_back(newEntry);
        if (bus.reg_dest_sel == 2'd3) modelErr = 1'b1;
        if (newEntry.we) nextMask[newEntry.wreg] = 1'b1;
      end
      modelMask = nextMask;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (randomReady) bus.out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.inst_rt      = '0;
    bus.inst_rd      = '0;
    bus.reg_dest_sel = 2'd0;
    bus.reg_write    = 1'b0;
    bus.out_ready    = 1'b1;
    bus.retire_valid = 1'b0;
    bus.retire_reg   = '0;
    bus.query_a      = '0;
    bus.query_b      = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstPending", bus.pending_mask, 32'd0);
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("rstErr", 32'(bus.err_illegal), 32'd0);
    @(posedge clk);
    #1;

    bus.query_a = 5'd12;
    bus.query_b = 5'd31;
    applyStimulus(5'd8, 5'd12, 2'd1, 1'b1);
    @(negedge clk);
    checkOutput("rdValid", 32'(bus.out_valid), 32'd1);
    checkOutput("rdWreg", 32'(bus.out_wreg), 32'd12);
    checkOutput("rdWe", 32'(bus.out_we), 32'd1);
    checkOutput("rdPend12", 32'(bus.pending_mask[12]), 32'd1);
    checkOutput("rdBusyA", 32'(bus.busy_a), 32'd1);
    @(posedge clk);
    #1;

    applyStimulus(5'd0, 5'd0, 2'd2, 1'b1);
    @(negedge clk);
    checkOutput("linkWreg", 32'(bus.out_wreg), 32'd31);
    checkOutput("linkPend31", 32'(bus.pending_mask[31]), 32'd1);
    checkOutput("linkBusyB", 32'(bus.busy_b), 32'd1);
    @(posedge clk);
    #1;

    applyStimulus(5'd9, 5'd0, 2'd1, 1'b1);
    @(negedge clk);
    checkOutput("r0We", 32'(bus.out_we), 32'd0);
    checkOutput("r0Mask", bus.pending_mask, 32'h8000_1000);
    @(posedge clk);
    #1;

    // Backpressure: two entries buffered, third held off by in_ready.
    bus.out_ready = 1'b0;
    applyStimulus(5'd0, 5'd3, 2'd1, 1'b1);
    applyStimulus(5'd0, 5'd4, 2'd1, 1'b1);
    @(negedge clk);
    checkOutput("skidInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("skidOutValid", 32'(bus.out_valid), 32'd1);
    checkOutput("skidOutWreg", 32'(bus.out_wreg), 32'd3);
    @(posedge clk);
    #1;
    bus.inst_rd      = 5'd5;
    bus.reg_dest_sel = 2'd1;
    bus.reg_write    = 1'b1;
    bus.in_valid     = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("heldInReady", 32'(bus.in_ready), 32'd0);
      checkOutput("heldOutWreg", 32'(bus.out_wreg), 32'd3);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus(5'd0, 5'd5, 2'd1, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Same-cycle set and retire of register 7, then a plain retire.
    applyStimulus(5'd0, 5'd7, 2'd1, 1'b1);
    @(negedge clk);
    checkOutput("pend7Set", 32'(bus.pending_mask[7]), 32'd1);
    @(posedge clk);
    #1;
    bus.retire_valid = 1'b1;
    bus.retire_reg   = 5'd7;
    applyStimulus(5'd0, 5'd7, 2'd1, 1'b1);
    bus.retire_valid = 1'b0;
    @(negedge clk);
    checkOutput("pend7SetWins", 32'(bus.pending_mask[7]), 32'd1);
    @(posedge clk);
    #1;
    bus.retire_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.retire_valid = 1'b0;
    @(negedge clk);
    checkOutput("pend7Retired", 32'(bus.pending_mask[7]), 32'd0);
    @(posedge clk);
    #1;
    bus.retire_valid = 1'b1;
    bus.retire_reg   = 5'd12;
    applyStimulus(5'd0, 5'd20, 2'd1, 1'b1);
    bus.retire_valid = 1'b0;
    @(negedge clk);
    checkOutput("pend12Retired", 32'(bus.pending_mask[12]), 32'd0);
    checkOutput("pend20Set", 32'(bus.pending_mask[20]), 32'd1);
    @(posedge clk);
    #1;

    // Random traffic with random downstream stalls and retires.
    randomReady = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.retire_valid = 1'($urandom_range(0, 1));
      bus.retire_reg   = REG_AW'($urandom_range(0, 31));
      bus.query_a      = REG_AW'($urandom_range(0, 31));
      bus.query_b      = REG_AW'($urandom_range(0, 31));
      applyStimulus(REG_AW'($urandom_range(0, 31)), REG_AW'($urandom_range(0, 31)),
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    bus.retire_valid = 1'b0;
    randomReady = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    applyStimulus(5'd5, 5'd9, 2'd3, 1'b1);
    @(negedge clk);
    checkOutput("illWe", 32'(bus.out_we), 32'd0);
    checkOutput("illWreg", 32'(bus.out_wreg), 32'd5);
    checkOutput("illErr", 32'(bus.err_illegal), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("illErrSticky", 32'(bus.err_illegal), 32'd1);
    @(posedge clk);
    #1;

    // Reset with both the output and skid registers occupied.
    bus.out_ready = 1'b0;
    applyStimulus(5'd0, 5'd10, 2'd1, 1'b1);
    applyStimulus(5'd0, 5'd11, 2'd1, 1'b1);
    @(negedge clk);
    checkOutput("preRstOutValid", 32'(bus.out_valid), 32'd1);
    checkOutput("preRstInReady", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("inRstInReady", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("midRstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRstOutWe", 32'(bus.out_we), 32'd0);
    checkOutput("midRstOutWreg", 32'(bus.out_wreg), 32'd0);
    checkOutput("midRstPending", bus.pending_mask, 32'd0);
    checkOutput("midRstErr", 32'(bus.err_illegal), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("postRstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("postRstOutValid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(5'd13, 5'd0, 2'd0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("queueEmpty", 32'(expQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
